muldiv_unit: RTL and testbench

Iterative multiply/divide execute unit for the RV32M extension, parametrised in datapath width. It sits beside the single-cycle ALU in the execute stage. The decode logic steers M-extension instructions here (opcode 0110011, funct7 = 0000001), and the pipeline stalls on `busy`. The unit decodes `funct3` internally, runs a radix-2 shift-add multiplier or restoring divider over WIDTH cycles, and returns a registered result with a one-cycle `done` pulse.

---
 rtl/muldiv_unit.sv | 88 ++++++++
 tb/tb_muldiv_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (shift-add multiplier, restoring divider)
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t state, state_n;
  logic [2:0] op;
  logic [WIDTH-1:0] opd;
  logic [2*WIDTH-1:0] acc, acc_step, prod;
  logic [CNT_W-1:0] cnt;
  logic neg_q, neg_r;
  logic sa, sb, na, nb, div_zero, ovf, fast, accept;
  logic [WIDTH-1:0] mag_a, mag_b, quo, rm, res_n;
  logic [WIDTH:0] msum, shifted, diff;
  assign sa = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign sb = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign na = sa & srcA[WIDTH-1];
  assign nb = sb & srcB[WIDTH-1];
  assign mag_a = na ? -srcA : srcA;
  assign mag_b = nb ? -srcB : srcB;
  assign div_zero = funct3[2] && (srcB == '0);
  assign ovf = funct3[2] && !funct3[0] && (srcA == {1'b1, {(WIDTH-1){1'b0}}}) && (srcB == {WIDTH{1'b1}});
  assign fast = div_zero | ovf;
  assign accept = (state == IDLE) && start && !flush;
  assign busy = (state != IDLE);
  // Multiplier adds the multiplicand into the high half; divider trial-subtracts the divisor.
  assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
  assign shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff = shifted - {1'b0, opd};
  assign acc_step = op[2] ? {diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]}
                          : {msum, acc[WIDTH-1:1]};
  // Sign correction: product/quotient take signA^signB, remainder takes signA.
  assign prod = neg_q ? -acc : acc;
  assign quo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rm = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign res_n = op[2] ? (op[1] ? rm : quo) : (op[1:0] == 2'b00 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
  // State register.
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // Next-state: fast-path divides skip CALC; flush aborts any in-flight op.
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = accept ? (fast ? FINISH : CALC) : IDLE;
      CALC:    state_n = flush ? IDLE : (cnt == CNT_W'(1) ? FINISH : CALC);
      default: state_n = IDLE;
    endcase
  end
  // Datapath: latch magnitudes on accept, iterate in CALC, register result in FINISH.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op <= '0;
      opd <= '0;
      acc <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      done <= 1'b0;
      result <= '0;
    end else begin
      done <= (state == FINISH) && !flush;
      if (state == FINISH && !flush) result <= res_n;
      if (accept) begin
        op <= funct3;
        cnt <= CNT_W'(WIDTH);
        opd <= funct3[2] ? mag_b : mag_a;
        acc <= div_zero ? {srcA, {WIDTH{1'b1}}} : ovf ? {{WIDTH{1'b0}}, srcA} : {{WIDTH{1'b0}}, funct3[2] ? mag_a : mag_b};
        neg_q <= !fast && (na ^ nb);
        neg_r <= !fast && na;
      end else if (state == CALC) begin
        acc <= acc_step;
        cnt <= cnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven scoreboard bench for muldiv_unit (32-bit and 8-bit instances)
module tb_muldiv_unit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] srcA = '0, srcB = '0, result;
  logic busy, done;
  logic start8 = 1'b0;
  logic [2:0] f8 = '0;
  logic [7:0] a8 = '0, b8 = '0, res8;
  logic busy8, done8;
  int cyc = 0, n_chk = 0, n_pass = 0, done_cnt = 0;
  typedef struct {logic [31:0] res; int cyc;} exp_t;
  typedef struct {logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic [31:0] e; int lat;} vec_t;
  exp_t sb[$];
  exp_t mx;
  vec_t vt[16];
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
    .srcA(srcA), .srcB(srcB), .busy(busy), .done(done), .result(result));
  muldiv_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(start8), .flush(1'b0), .funct3(f8),
    .srcA(a8), .srcB(b8), .busy(busy8), .done(done8), .result(res8));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask
  // Scoreboard: every done pops one expectation and checks value and arrival cycle.
  always @(negedge clk)
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_done: result %0h with no op pending", result);
      end else begin
        mx = sb.pop_front();
        chk("result", {32'd0, result}, {32'd0, mx.res});
        chk("done_cycle", 64'(cyc), 64'(mx.cyc));
      end
    end
  task automatic wait_drain(output int bc);
    int t;
    bc = 0;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      if (busy) bc++;
      t++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL timeout: %0d ops still pending", sb.size());
      sb.delete();
    end
  endtask
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e, input int lat);
    int bc;
    @(negedge clk);
    start = 1'b1; funct3 = f; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back('{e, cyc + lat});
    wait_drain(bc);
    chk("busy_cycles", 64'(bc), 64'(lat));
  endtask
  initial begin
    int bc, c0, d0;
    vt[0]  = '{3'b000, 32'hFFFFFFFE, 32'd7, 32'hFFFFFFF2, 33};
    vt[1]  = '{3'b001, 32'hFFFFFFFE, 32'd7, 32'hFFFFFFFF, 33};
    vt[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vt[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33};
    vt[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33};
    vt[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33};
    vt[6]  = '{3'b101, 32'd100, 32'd7, 32'd14, 33};
    vt[7]  = '{3'b111, 32'd100, 32'd7, 32'd2, 33};
    vt[8]  = '{3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1};
    vt[9]  = '{3'b110, 32'd5, 32'd0, 32'd5, 1};
    vt[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vt[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1};
    vt[12] = '{3'b000, 32'd12345, 32'd6789, 32'h04FED79D, 33};
    vt[13] = '{3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vt[14] = '{3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 33};
    vt[15] = '{3'b001, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'd0, 33};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_result", {32'd0, result}, 64'd0);
    foreach (vt[i]) run_op(vt[i].f3, vt[i].a, vt[i].b, vt[i].e, vt[i].lat);
    // start re-pulsed while busy must be ignored
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; srcA = 32'd12345; srcB = 32'd6789;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back('{32'h04FED79D, cyc + 33});
    repeat (5) @(negedge clk);
    start = 1'b1; funct3 = 3'b101; srcA = 32'd5; srcB = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain(bc);
    repeat (40) @(negedge clk);
    chk("single_done", 64'(done_cnt - d0), 64'd1);
    // start held high across done: second op accepted in the done cycle
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; srcA = 32'd100; srcB = 32'd7;
    @(posedge clk); #1;
    c0 = cyc;
    sb.push_back('{32'd14, c0 + 33});
    sb.push_back('{32'h04FED79D, c0 + 67});
    funct3 = 3'b000; srcA = 32'd12345; srcB = 32'd6789;
    bc = 0;
    while (sb.size() > 1 && bc < 100) begin @(negedge clk); bc++; end
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain(bc);
    // flush during CALC: no done, busy drops, result held
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b011; srcA = 32'hFFFFFFFF; srcB = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_done", {63'd0, done}, 64'd0);
    chk("flush_result", {32'd0, result}, 64'h04FED79D);
    repeat (40) @(negedge clk);
    chk("flush_no_done", 64'(done_cnt - d0), 64'd0);
    // flush and start together in IDLE: no accept
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b101; srcA = 32'd9; srcB = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {63'd0, busy}, 64'd0);
    repeat (5) @(negedge clk);
    chk("flush_start_no_done", 64'(done_cnt - d0), 64'd0);
    // asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; srcA = 32'd3; srcB = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_result", {32'd0, result}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("arst_no_done", 64'(done_cnt - d0), 64'd0);
    run_op(3'b111, 32'd100, 32'd7, 32'd2, 33);
    // WIDTH=8 instance: mulhu 0xFF*0xFF, latency 9
    @(negedge clk);
    start8 = 1'b1; f8 = 3'b011; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    c0 = cyc;
    bc = 0;
    while (!done8 && bc < 50) begin @(negedge clk); bc++; end
    chk("w8_result", {56'd0, res8}, 64'hFE);
    chk("w8_latency", 64'(cyc - c0), 64'd9);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
